// File: rtl/phased_delay_line.sv
// Circular-buffer delay line for one ADC channel. Each accepted sample is
// replayed a programmable number of accepted samples later.
module phased_delay_line #(
  parameter int DATA_W     = 10,
  parameter int DEPTH_LOG2 = 9,
  parameter int CHANNEL    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  new_sample,
  input  logic [DATA_W-1:0]     sample,
  input  logic [3:0]            sample_channel,
  input  logic                  clear,
  input  logic                  delay_load,
  input  logic [DEPTH_LOG2-1:0] delay_in,
  output logic [DEPTH_LOG2-1:0] delay_q,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_sample,
  output logic                  primed
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] FILL_MAX = DEPTH_LOG2'(DEPTH - 1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [3:0]            CHAN_ID  = 4'(CHANNEL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
  logic [DEPTH_LOG2-1:0] fillCnt_q, fillCnt_d;
  logic [DEPTH_LOG2-1:0] delayReg_q, delayReg_d;
  logic                  pendValid_q, pendBypass_q, pendZero_q;
  logic [DATA_W-1:0]     bypassData_q, heldSample_q, ramData_q;

  logic                  accept, doWrite;
  logic [DEPTH_LOG2-1:0] effDelay, rdAddr;
  logic [DATA_W-1:0]     selected;

  always_comb begin
    accept     = new_sample && (sample_channel == CHAN_ID);
    doWrite    = accept && !clear;
    effDelay   = delay_load ? delay_in : delayReg_q;
    rdAddr     = wrPtr_q - effDelay;
    wrPtr_d    = wrPtr_q;
    fillCnt_d  = fillCnt_q;
    delayReg_d = delayReg_q;
    if (delay_load) delayReg_d = delay_in;
    if (clear) begin
      wrPtr_d   = '0;
      fillCnt_d = '0;
    end else if (accept) begin
      wrPtr_d   = wrPtr_q + PTR_ONE;
      fillCnt_d = (fillCnt_q == FILL_MAX) ? fillCnt_q : fillCnt_q + PTR_ONE;
    end
    // Zero delay bypasses the RAM so read-during-write data is never relied on.
    selected = '0;
    if (pendBypass_q)    selected = bypassData_q;
    else if (!pendZero_q) selected = ramData_q;
    out_sample = pendValid_q ? selected : heldSample_q;
    out_valid  = pendValid_q;
    primed     = (fillCnt_q >= delayReg_q);
    delay_q    = delayReg_q;
  end

  // Block RAM: synchronous read-before-write, contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && doWrite) mem[wrPtr_q] <= sample;
    ramData_q <= mem[rdAddr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q      <= '0;
      fillCnt_q    <= '0;
      delayReg_q   <= '0;
      pendValid_q  <= 1'b0;
      pendBypass_q <= 1'b0;
      pendZero_q   <= 1'b0;
      bypassData_q <= '0;
      heldSample_q <= '0;
    end else begin
      wrPtr_q      <= wrPtr_d;
      fillCnt_q    <= fillCnt_d;
      delayReg_q   <= delayReg_d;
      pendValid_q  <= doWrite;
      pendBypass_q <= (effDelay == '0);
      pendZero_q   <= (fillCnt_q < effDelay);
      bypassData_q <= sample;
      heldSample_q <= out_sample;
    end
  end

endmodule

// File: tb/tb_phased_delay_line.sv
// Scoreboard bench for phased_delay_line: a history model predicts each delayed
// sample when it is driven, and the monitor pops and compares on out_valid.
module tb_phased_delay_line;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_sample = 1'b0;
  logic [9:0] sample = '0;
  logic [3:0] sample_channel = '0;
  logic       clear = 1'b0;
  logic       delay_load = 1'b0;
  logic [8:0] delay_in = '0;
  logic [8:0] delay_q;
  logic       out_valid;
  logic [9:0] out_sample;
  logic       primed;

  int checks = 0;
  int failures = 0;

  logic [9:0] expQ[$];
  logic [9:0] hist[$];
  int         modelDelay = 0;

  phased_delay_line dut (
    .clk(clk), .rst_n(rst_n), .new_sample(new_sample), .sample(sample),
    .sample_channel(sample_channel), .clear(clear), .delay_load(delay_load),
    .delay_in(delay_in), .delay_q(delay_q), .out_valid(out_valid),
    .out_sample(out_sample), .primed(primed)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: every out_valid must match the oldest prediction.
  always @(negedge clk) begin
    if (out_valid) begin
      if (expQ.size() == 0) checkOutput("spurious_valid", 32'd1, 32'd0);
      else checkOutput("out_sample", 32'(out_sample), 32'(expQ.pop_front()));
    end
  end

  task automatic applyStimulus(input bit ns, input logic [3:0] ch, input logic [9:0] val,
                               input bit ld, input logic [8:0] dly, input bit clr, input bit rst);
    int fill;
    new_sample = ns; sample_channel = ch; sample = val;
    delay_load = ld; delay_in = dly; clear = clr; rst_n = !rst;
    if (rst) begin
      hist.delete();
      modelDelay = 0;
    end else begin
      if (ld) modelDelay = int'(dly);
      if (clr) hist.delete();
      else if (ns && ch == 4'd0) begin
        fill = (hist.size() > 511) ? 511 : hist.size();
        if (modelDelay == 0) expQ.push_back(val);
        else if (fill >= modelDelay) expQ.push_back(hist[hist.size() - modelDelay]);
        else expQ.push_back(10'd0);
        hist.push_back(val);
      end
    end
    @(posedge clk);
    #1;
    new_sample = 1'b0; delay_load = 1'b0; clear = 1'b0; rst_n = 1'b1;
    fill = (hist.size() > 511) ? 511 : hist.size();
    checkOutput("primed", 32'(primed), 32'(fill >= modelDelay));
    checkOutput("delay_q", 32'(delay_q), 32'(modelDelay));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 4'd0, 10'd0, 0, 9'd0, 0, 0);
  endtask

  initial begin
    applyStimulus(0, 4'd0, 10'd0, 0, 9'd0, 0, 1);
    applyStimulus(0, 4'd0, 10'd0, 0, 9'd0, 0, 1);
    checkOutput("reset_out_sample", 32'(out_sample), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);

    // Bypass with zero delay.
    for (int i = 1; i <= 3; i++) applyStimulus(1, 4'd0, 10'(i), 0, 9'd0, 0, 0);
    idle(2);

    // Ramp with delay 4 from an empty history.
    applyStimulus(0, 4'd0, 10'd0, 1, 9'd4, 1, 0);
    for (int i = 10; i <= 19; i++) applyStimulus(1, 4'd0, 10'(i), 0, 9'd0, 0, 0);
    idle(1);

    // Foreign channel strobes interleaved.
    for (int i = 0; i < 8; i++)
      applyStimulus(1, (i % 2 == 0) ? 4'd0 : 4'd3, 10'(100 + i), 0, 9'd0, 0, 0);
    idle(3);
    checkOutput("held_out_sample", 32'(out_sample), 32'(hist[hist.size() - 5]));

    // Maximum delay with pointer wrap.
    applyStimulus(0, 4'd0, 10'd0, 1, 9'd511, 1, 0);
    for (int n = 0; n < 600; n++) begin
      applyStimulus(1, 4'd0, 10'(n % 1024), 0, 9'd0, 0, 0);
      if (n % 7 == 0) idle(1);
    end
    idle(1);

    // Delay change coincident with an accept.
    applyStimulus(0, 4'd0, 10'd0, 1, 9'd3, 1, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 4'd0, 10'(200 + i), 0, 9'd0, 0, 0);
    applyStimulus(1, 4'd0, 10'd300, 1, 9'd5, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 4'd0, 10'(301 + i), 0, 9'd0, 0, 0);
    applyStimulus(1, 4'd0, 10'd400, 1, 9'd20, 0, 0);
    idle(1);

    // Clear coincident with accept, refill, then reset mid-stream.
    applyStimulus(1, 4'd0, 10'd500, 1, 9'd2, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 4'd0, 10'(510 + i), 0, 9'd0, 0, 0);
    applyStimulus(1, 4'd0, 10'd600, 0, 9'd0, 0, 1);
    idle(1);
    checkOutput("rst_out_sample", 32'(out_sample), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 4'd0, 10'(700 + i), 0, 9'd0, 0, 0);
    idle(3);

    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
